// File: rtl/multicycle_control_pkg.sv
// Purpose: shared constants for the multi-cycle MIPS sequencer (opcodes, state codes, mux selects).
// Latency: n/a (constants only).
// Backpressure: n/a.
package mips_ctrl_pkg;

   // Instruction opcodes, instr[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // Sequencer state encodings; codes 13 and 14 are unused
   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_FETCH     = 4'd1;
   localparam logic [3:0] S_DECODE    = 4'd2;
   localparam logic [3:0] S_MEM_ADDR  = 4'd3;
   localparam logic [3:0] S_MEM_READ  = 4'd4;
   localparam logic [3:0] S_MEM_WB    = 4'd5;
   localparam logic [3:0] S_MEM_WRITE = 4'd6;
   localparam logic [3:0] S_EXECUTE   = 4'd7;
   localparam logic [3:0] S_ALU_WB    = 4'd8;
   localparam logic [3:0] S_BRANCH    = 4'd9;
   localparam logic [3:0] S_JUMP      = 4'd10;
   localparam logic [3:0] S_ADDI_EXEC = 4'd11;
   localparam logic [3:0] S_ADDI_WB   = 4'd12;
   localparam logic [3:0] S_HALT      = 4'd15;

   // ALU B-operand select
   localparam logic [1:0] ALUB_RT     = 2'b00;
   localparam logic [1:0] ALUB_FOUR   = 2'b01;
   localparam logic [1:0] ALUB_IMM    = 2'b10;
   localparam logic [1:0] ALUB_IMM_SH = 2'b11;

   // ALU operation select
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Next-PC source select
   localparam logic [1:0] PCS_ALU     = 2'b00;
   localparam logic [1:0] PCS_ALUOUT  = 2'b01;
   localparam logic [1:0] PCS_JUMP    = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Purpose: groups the sequencer's datapath-facing inputs and control outputs.
// Latency: n/a (wiring only).
// Backpressure: memory stalls arrive on mem_ready; there is no other flow control.
interface multicycle_control_if #(
   parameter int COUNT_W = 32
);
   logic               run;
   logic [5:0]         opcode;
   logic               mem_ready;
   logic               pc_write;
   logic               pc_write_cond;
   logic               i_or_d;
   logic               mem_read;
   logic               mem_write;
   logic               ir_write;
   logic               reg_dst;
   logic               mem_to_reg;
   logic               reg_write;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [1:0]         alu_op;
   logic [1:0]         pc_source;
   logic [3:0]         state;
   logic               halted;
   logic               instr_done;
   logic [COUNT_W-1:0] instr_count;

   // Controller side
   modport master (
      input  run, opcode, mem_ready,
      output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, state, halted, instr_done, instr_count
   );

   // Datapath / environment side
   modport slave (
      output run, opcode, mem_ready,
      input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, state, halted, instr_done, instr_count
   );
endinterface

// File: rtl/multicycle_control.sv
// Purpose: Moore sequencer for the multi-cycle MIPS datapath plus retired-instruction counter.
// Latency: LW 5, SW/R/ADDI 4, BEQ/J 3 cycles; each mem_ready=0 cycle in a memory state adds one.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold until mem_ready; run only acts at instruction boundaries.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int COUNT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   multicycle_control_if.master bus
);

   logic [3:0]         r_state;
   logic [3:0]         w_next;
   logic               w_done;
   logic [COUNT_W-1:0] r_count;

   // Instruction completes in its final state; a store completes only once memory accepts it
   always_comb begin
      w_done = 1'b0;
      case (r_state)
         S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB: w_done = 1'b1;
         S_MEM_WRITE:                                    w_done = bus.mem_ready;
         default:                                        w_done = 1'b0;
      endcase
   end

   // Next-state selection
   always_comb begin
      w_next = r_state;
      if (w_done) begin
         w_next = bus.run ? S_FETCH : S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:      if (bus.run) w_next = S_FETCH;
            S_FETCH:     if (bus.mem_ready) w_next = S_DECODE;
            S_DECODE: begin
               case (bus.opcode)
                  OP_LW, OP_SW: w_next = S_MEM_ADDR;
                  OP_RTYPE:     w_next = S_EXECUTE;
                  OP_BEQ:       w_next = S_BRANCH;
                  OP_J:         w_next = S_JUMP;
                  OP_ADDI:      w_next = S_ADDI_EXEC;
                  default:      w_next = S_HALT;
               endcase
            end
            // Opcode is held by the IR, so it still tells load from store here
            S_MEM_ADDR:  w_next = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (bus.mem_ready) w_next = S_MEM_WB;
            S_MEM_WRITE: w_next = S_MEM_WRITE;
            S_EXECUTE:   w_next = S_ALU_WB;
            S_ADDI_EXEC: w_next = S_ADDI_WB;
            S_HALT:      w_next = S_HALT;
            // Unused encodings recover to IDLE rather than wedging
            default:     w_next = S_IDLE;
         endcase
      end
   end

   // State register; reset wins even in the middle of a memory wait
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Retired-instruction counter, wraps silently
   always_ff @(posedge clk) begin
      if (!rst_n)      r_count <= '0;
      else if (w_done) r_count <= r_count + 1'b1;
   end

   // Datapath control decode; only FETCH's PC/IR loads look at mem_ready
   always_comb begin
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.i_or_d        = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_write     = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = ALUB_RT;
      bus.alu_op        = ALUOP_ADD;
      bus.pc_source     = PCS_ALU;
      bus.halted        = 1'b0;
      case (r_state)
         S_FETCH: begin
            bus.mem_read  = 1'b1;
            bus.alu_src_b = ALUB_FOUR;
            bus.ir_write  = bus.mem_ready;
            bus.pc_write  = bus.mem_ready;
         end
         S_DECODE: bus.alu_src_b = ALUB_IMM_SH;
         S_MEM_ADDR, S_ADDI_EXEC: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = ALUB_IMM;
         end
         S_MEM_READ: begin
            bus.mem_read = 1'b1;
            bus.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            bus.mem_write = 1'b1;
            bus.i_or_d    = 1'b1;
         end
         S_EXECUTE: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = ALUOP_FUNCT;
         end
         S_ALU_WB: begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            bus.alu_src_a     = 1'b1;
            bus.alu_op        = ALUOP_SUB;
            bus.pc_write_cond = 1'b1;
            bus.pc_source     = PCS_ALUOUT;
         end
         S_JUMP: begin
            bus.pc_write  = 1'b1;
            bus.pc_source = PCS_JUMP;
         end
         S_ADDI_WB: bus.reg_write = 1'b1;
         S_HALT:    bus.halted    = 1'b1;
         default: ;
      endcase
   end

   assign bus.state       = r_state;
   assign bus.instr_done  = w_done;
   assign bus.instr_count = r_count;

endmodule
